branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumer of the comparator flags in the execute stage.
- Accepts one branch or jump per handshake and compares src_1/src_2 through an embedded comparator.
- Registers the decision: taken, target, link, misprediction.
- On a misprediction, issues a one-cycle redirect to fetch, then holds a flush window for a fixed number of cycles.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- FLUSH_CYCLES, 2, cycles flush is held after a redirect; 0 to 15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- funct3  in  3  branch condition (RV32I encoding)
- is_jal  in  1  unconditional, target pc+imm
- is_jalr  in  1  unconditional, target (src_1+imm)&~1
- pc  in  32  instruction address
- imm  in  32  sign-extended offset
- src_1  in  32  rs1 value
- src_2  in  32  rs2 value
- pred_taken  in  1  fetch prediction
- pred_target  in  32  fetch predicted target
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- taken  out  1  resolved direction
- target  out  32  resolved taken target
- link  out  32  pc+4
- mispredict  out  1  prediction wrong
- misaligned  out  1  taken and target[1]=1
- illegal  out  1  funct3 is 010 or 011 with no jump flag
- redirect_valid  out  1  one-cycle pulse to fetch
- redirect_pc  out  32  next fetch address
- flush  out  1  squash younger instructions

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE and the flush counter to 0.
  - All outputs go to 0; in_ready is 1 in the cycle after reset.
  - Reset mid-OUT or mid-FLUSH discards the pending result with no redirect.
- Condition select, from comparator flags:
  - 000 equal; 001 !equal; 100 signed_less; 101 !signed_less; 110 less; 111 !less.
  - 010/011 give taken=0 and illegal=1.
  - is_jal or is_jalr forces taken=1 and overrides funct3; is_jalr has priority if both are set.
- Arithmetic: 32-bit modulo 2^32, with no overflow detection. pc+imm, src_1+imm and pc+4 all wrap (pc=0xFFFFFFFC gives link=0x00000000).
- mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target). It is forced to 0 when illegal or misaligned.
- redirect_pc = taken ? target : link.
- Latency: the result is registered, with out_valid 1 cycle after acceptance. Outputs stay stable while out_valid & !out_ready.
- State machine:
  - IDLE: in_ready=1. Acceptance moves to OUT.
  - OUT: out_valid=1; in_ready = out_ready & !mispredict.
    - Handshake with mispredict: redirect_valid=1 in that same cycle, combinationally with the out handshake. Next state is FLUSH with counter=FLUSH_CYCLES, or IDLE if FLUSH_CYCLES=0.
    - Handshake without mispredict: accept a simultaneous in_valid and stay in OUT, giving back-to-back throughput of 1 per cycle. Otherwise go to IDLE.
  - FLUSH: flush=1 and in_ready=0. The counter decrements each cycle; at 1 the next state is IDLE.
- redirect_valid is never asserted outside an OUT handshake, and never for more than 1 cycle per result.
- misaligned and illegal results complete normally with out_valid and no redirect; trap handling is downstream.

Decomposition:
- Shared package: funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU), state enum constants (IDLE, OUT, FLUSH), XLEN default.
- Sub-module: instantiate the existing comp for the flags. Condition select and target adders stay inline.

Test Plan:
- BEQ: src_1=src_2=0x10, pc=0x100, imm=0x20, pred_taken=0. Expect out_valid next cycle, taken=1, target=0x120, mispredict=1. redirect_valid pulses with redirect_pc=0x120; flush high for 2 cycles; in_ready low until IDLE.
- BLT vs BLTU with src_1=0xFFFFFFFF, src_2=1:
  - BLT gives taken=1.
  - BLTU gives taken=0.
  - Both with pred_taken matching: no redirect, and back-to-back acceptance with out_ready=1 every cycle.
- JALR: src_1=0x1003, imm=0, pred_taken=1, pred_target=0x1000. Expect target=0x1002, misaligned=1, mispredict=0, no redirect.
- Backpressure: out_ready=0 for 3 cycles. Outputs held stable, in_ready=0, single redirect_valid pulse only on the handshake cycle.
- Wrap and illegal:
  - pc=0xFFFFFFFC, not-taken BNE gives link=0x0.
  - funct3=010 gives illegal=1, taken=0.
  - rst asserted during FLUSH: flush=0 and in_ready=1 the next cycle.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared constants and state encoding for branch resolution
package branch_resolve_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUT   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_resolve_comp.sv
// rtl/branch_resolve_comp.sv - equality and signed/unsigned less-than flags for two operands
module branch_resolve_comp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src_1,
    input  logic [XLEN-1:0] src_2,
    output logic            equal,
    output logic            signed_less,
    output logic            less
);

    assign equal       = (src_1 == src_2);
    assign signed_less = ($signed(src_1) < $signed(src_2));
    assign less        = (src_1 < src_2);

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - resolves branches/jumps, registers the decision and drives redirect/flush
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] src_1,
    input  logic [XLEN-1:0] src_2,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            mispredict,
    output logic            misaligned,
    output logic            illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t          state, state_next;
    logic [3:0]      cnt;
    logic            equal, signed_less, less;
    logic            accept, out_hs;
    logic            cond_taken, taken_d, illegal_d, misaligned_d, mispredict_d;
    logic [XLEN-1:0] sum_pc, sum_rs, target_d, link_d;

    branch_resolve_comp #(.XLEN(XLEN)) u_comp (
        .src_1       (src_1),
        .src_2       (src_2),
        .equal       (equal),
        .signed_less (signed_less),
        .less        (less)
    );

    always_comb begin
        sum_pc     = pc + imm;
        sum_rs     = src_1 + imm;
        link_d     = pc + XLEN'(4);
        target_d   = is_jalr ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
        cond_taken = 1'b0;
        illegal_d  = 1'b0;
        case (funct3)
            BEQ:     cond_taken = equal;
            BNE:     cond_taken = !equal;
            BLT:     cond_taken = signed_less;
            BGE:     cond_taken = !signed_less;
            BLTU:    cond_taken = less;
            BGEU:    cond_taken = !less;
            default: illegal_d  = 1'b1;
        endcase
        // Jumps ignore funct3 entirely, including the reserved encodings.
        if (is_jal || is_jalr) begin
            cond_taken = 1'b1;
            illegal_d  = 1'b0;
        end
        taken_d      = cond_taken;
        misaligned_d = taken_d & target_d[1];
        mispredict_d = !(illegal_d || misaligned_d)
                     && ((taken_d != pred_taken)
                         || (taken_d && pred_taken && (target_d != pred_target)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = OUT;
            OUT: begin
                if (out_hs) begin
                    if (mispredict) state_next = (FLUSH_INIT == 4'd0) ? IDLE : FLUSH;
                    else            state_next = accept ? OUT : IDLE;
                end
            end
            FLUSH:   if (cnt <= 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        flush          = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready & !mispredict;
            end
            FLUSH:   flush = 1'b1;
            default: in_ready = 1'b0;
        endcase
        accept         = in_valid & in_ready;
        out_hs         = out_valid & out_ready;
        redirect_valid = out_hs & mispredict;
        redirect_pc    = taken ? target : link;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (redirect_valid) begin
            cnt <= FLUSH_INIT;
        end else if (state == FLUSH && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken      <= 1'b0;
            target     <= '0;
            link       <= '0;
            mispredict <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            taken      <= taken_d;
            target     <= target_d;
            link       <= link_d;
            mispredict <= mispredict_d;
            misaligned <= misaligned_d;
            illegal    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
module tb_branch_resolve;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mispredict;
        logic        misaligned;
        logic        illegal;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'b000;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] src_1 = '0;
    logic [31:0] src_2 = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mispredict;
    logic        misaligned;
    logic        illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;

    int   tests = 0;
    int   fails = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .is_jal(is_jal), .is_jalr(is_jalr), .pc(pc), .imm(imm),
        .src_1(src_1), .src_2(src_2), .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
        .link(link), .mispredict(mispredict), .misaligned(misaligned), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] f3, input logic jal, input logic jalr,
                                   input logic [31:0] p, input logic [31:0] i,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic pt, input logic [31:0] ptg);
        res_t r;
        r.link    = p + 32'd4;
        r.target  = jalr ? ((a + i) & 32'hFFFF_FFFE) : (p + i);
        r.illegal = 1'b0;
        if (jal || jalr) r.taken = 1'b1;
        else begin
            case (f3)
                3'b000:  r.taken = (a == b);
                3'b001:  r.taken = (a != b);
                3'b100:  r.taken = ($signed(a) < $signed(b));
                3'b101:  r.taken = ($signed(a) >= $signed(b));
                3'b110:  r.taken = (a < b);
                3'b111:  r.taken = (a >= b);
                default: begin r.taken = 1'b0; r.illegal = 1'b1; end
            endcase
        end
        r.misaligned = r.taken & r.target[1];
        if (r.illegal || r.misaligned) r.mispredict = 1'b0;
        else if (r.taken)              r.mispredict = !pt || (r.target != ptg);
        else                           r.mispredict = pt;
        return r;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic [31:0] ptg, output int cyc);
        logic acc;
        funct3 = f3; is_jal = jal; is_jalr = jalr; pc = p; imm = i;
        src_1 = a; src_2 = b; pred_taken = pt; pred_target = ptg;
        in_valid = 1'b1;
        sb.push_back(model(f3, jal, jalr, p, i, a, b, pt, ptg));
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) chk("accept_timeout", 32'(cyc), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_unexpected got=result exp=none");
                end else begin
                    e = sb.pop_front();
                    chk("sb_taken", 32'(taken), 32'(e.taken));
                    chk("sb_target", target, e.target);
                    chk("sb_link", link, e.link);
                    chk("sb_mispredict", 32'(mispredict), 32'(e.mispredict));
                    chk("sb_misaligned", 32'(misaligned), 32'(e.misaligned));
                    chk("sb_illegal", 32'(illegal), 32'(e.illegal));
                    chk("sb_redirect_valid", 32'(redirect_valid), 32'(e.mispredict));
                    if (e.mispredict)
                        chk("sb_redirect_pc", redirect_pc, e.taken ? e.target : e.link);
                end
            end else begin
                chk("redirect_idle", 32'(redirect_valid), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_target", target, 32'd0);

        // BEQ taken, predicted not-taken
        out_ready = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 32'h100, 32'h20, 32'h10, 32'h10, 1'b0, 32'h0, cyc);
        chk("beq_lat", 32'(cyc), 32'd1);
        chk("beq_out_valid", 32'(out_valid), 32'd1);
        chk("beq_taken", 32'(taken), 32'd1);
        chk("beq_target", target, 32'h120);
        chk("beq_mispredict", 32'(mispredict), 32'd1);
        chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_in_ready_out", 32'(in_ready), 32'd0);
        cycle();
        chk("beq_flush1", 32'(flush), 32'd1);
        chk("beq_in_ready_f1", 32'(in_ready), 32'd0);
        chk("beq_redirect_f1", 32'(redirect_valid), 32'd0);
        cycle();
        chk("beq_flush2", 32'(flush), 32'd1);
        chk("beq_in_ready_f2", 32'(in_ready), 32'd0);
        cycle();
        chk("beq_flush_end", 32'(flush), 32'd0);
        chk("beq_in_ready_idle", 32'(in_ready), 32'd1);

        // BLT vs BLTU back-to-back, correctly predicted
        drive(3'b100, 1'b0, 1'b0, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h240, cyc);
        chk("blt_lat", 32'(cyc), 32'd1);
        chk("blt_taken", 32'(taken), 32'd1);
        chk("blt_in_ready", 32'(in_ready), 32'd1);
        drive(3'b110, 1'b0, 1'b0, 32'h204, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, cyc);
        chk("bltu_b2b_lat", 32'(cyc), 32'd1);
        chk("bltu_taken", 32'(taken), 32'd0);
        drive(3'b111, 1'b0, 1'b0, 32'h208, 32'h8, 32'h5, 32'h5, 1'b1, 32'h210, cyc);
        chk("bgeu_b2b_lat", 32'(cyc), 32'd1);
        chk("bgeu_taken", 32'(taken), 32'd1);
        cycle();
        chk("b2b_idle_out_valid", 32'(out_valid), 32'd0);

        // JALR to a misaligned target
        drive(3'b000, 1'b0, 1'b1, 32'h300, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h1000, cyc);
        chk("jalr_target", target, 32'h1002);
        chk("jalr_misaligned", 32'(misaligned), 32'd1);
        chk("jalr_mispredict", 32'(mispredict), 32'd0);
        chk("jalr_link", link, 32'h304);
        cycle();

        // JAL overriding a reserved funct3
        drive(3'b011, 1'b1, 1'b0, 32'h380, 32'h100, 32'h0, 32'h0, 1'b1, 32'h480, cyc);
        chk("jal_taken", 32'(taken), 32'd1);
        chk("jal_illegal", 32'(illegal), 32'd0);
        cycle();

        // backpressure on a mispredicted BNE
        out_ready = 1'b0;
        drive(3'b001, 1'b0, 1'b0, 32'h400, 32'h10, 32'h1, 32'h2, 1'b0, 32'h0, cyc);
        for (int k = 0; k < 3; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_target", target, 32'h410);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_redirect", 32'(redirect_valid), 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_redirect_hs", 32'(redirect_valid), 32'd1);
        chk("bp_redirect_pc", redirect_pc, 32'h410);
        cycle();
        chk("bp_flush", 32'(flush), 32'd1);
        chk("bp_redirect_after", 32'(redirect_valid), 32'd0);
        repeat (2) cycle();

        // wrap-around link on not-taken BNE
        drive(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h5, 32'h5, 1'b0, 32'h0, cyc);
        chk("wrap_link", link, 32'h0);
        chk("wrap_taken", 32'(taken), 32'd0);
        chk("wrap_redirect", 32'(redirect_valid), 32'd0);
        cycle();

        // reserved funct3
        drive(3'b010, 1'b0, 1'b0, 32'h500, 32'h4, 32'h7, 32'h7, 1'b1, 32'h504, cyc);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_taken", 32'(taken), 32'd0);
        chk("ill_mispredict", 32'(mispredict), 32'd0);
        cycle();

        // reset while flushing
        drive(3'b000, 1'b0, 1'b0, 32'h600, 32'h20, 32'h3, 32'h3, 1'b0, 32'h0, cyc);
        cycle();
        chk("rstf_flush_before", 32'(flush), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstf_flush", 32'(flush), 32'd0);
        chk("rstf_in_ready", 32'(in_ready), 32'd1);
        chk("rstf_out_valid", 32'(out_valid), 32'd0);
        chk("rstf_redirect", 32'(redirect_valid), 32'd0);

        repeat (3) cycle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
